uart_cmd_parser: RTL and testbench

//  Consumes the byte stream from the UART receiver (one-cycle valid strobes) and parses fixed 5-byte

---
 rtl/uart_cmd_parser_if.sv | 23 ++
 rtl/uart_cmd_parser.sv | 219 +++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_parser_if.sv
// rtl/uart_cmd_parser_if.sv - received byte stream and loop configuration bundle for uart_cmd_parser
interface uart_cmd_parser_if;
  logic               rx_data_valid;
  logic [7:0]         rx_data;
  logic signed [15:0] rpm_set_o;
  logic [15:0]        kp_o;
  logic [15:0]        ki_o;
  logic [15:0]        kd_o;
  logic               motor_en_o;
  logic               cfg_update_o;
  logic               frame_err_o;
  logic [1:0]         err_code_o;

  modport master (
    output rx_data_valid, rx_data,
    input  rpm_set_o, kp_o, ki_o, kd_o, motor_en_o, cfg_update_o, frame_err_o, err_code_o
  );

  modport slave (
    input  rx_data_valid, rx_data,
    output rpm_set_o, kp_o, ki_o, kd_o, motor_en_o, cfg_update_o, frame_err_o, err_code_o
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - parses A5/CMD/DH/DL/CHK frames into speed setpoint and PID gains
module uart_cmd_parser #(
  parameter int                 TIMEOUT_CYC = 27_000,
  parameter logic signed [15:0] RPM_MAX     = 16'sd300,
  parameter logic [15:0]        KP_INIT     = 16'd256,
  parameter logic [15:0]        KI_INIT     = 16'd16,
  parameter logic [15:0]        KD_INIT     = 16'd0
) (
  input logic               clk,
  input logic               rstn,
  uart_cmd_parser_if.slave  bus
);

  localparam int              CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      HDR      = 8'hA5;

  localparam logic [7:0] CMD_SET_RPM = 8'h01;
  localparam logic [7:0] CMD_SET_KP  = 8'h02;
  localparam logic [7:0] CMD_SET_KI  = 8'h03;
  localparam logic [7:0] CMD_SET_KD  = 8'h04;
  localparam logic [7:0] CMD_STOP    = 8'h05;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CHK  = 2'b01;
  localparam logic [1:0] ERR_CMD  = 2'b10;
  localparam logic [1:0] ERR_TO   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DH,
    S_DL,
    S_CHK
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [7:0]         dh_q, dh_d;
  logic [7:0]         dl_q, dl_d;

  // Frame decode is split from the register commit so the CHK byte edge only resolves the checksum.
  logic               pend_frame_q, pend_frame_d;
  logic               pend_ok_q, pend_ok_d;
  logic               pend_to_q, pend_to_d;

  logic signed [15:0] rpm_q, rpm_d;
  logic [15:0]        kp_q, kp_d;
  logic [15:0]        ki_q, ki_d;
  logic [15:0]        kd_q, kd_d;
  logic               en_q, en_d;
  logic               cfg_q, cfg_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;

  logic signed [15:0] data_s;
  logic signed [15:0] rpm_clamped;

  assign data_s = $signed({dh_q, dl_q});

  always_comb begin
    rpm_clamped = data_s;
    if (data_s > RPM_MAX) begin
      rpm_clamped = RPM_MAX;
    end else if (data_s < -RPM_MAX) begin
      rpm_clamped = -RPM_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cmd_q        <= '0;
      dh_q         <= '0;
      dl_q         <= '0;
      pend_frame_q <= 1'b0;
      pend_ok_q    <= 1'b0;
      pend_to_q    <= 1'b0;
      rpm_q        <= '0;
      kp_q         <= KP_INIT;
      ki_q         <= KI_INIT;
      kd_q         <= KD_INIT;
      en_q         <= 1'b0;
      cfg_q        <= 1'b0;
      err_q        <= 1'b0;
      code_q       <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      dh_q         <= dh_d;
      dl_q         <= dl_d;
      pend_frame_q <= pend_frame_d;
      pend_ok_q    <= pend_ok_d;
      pend_to_q    <= pend_to_d;
      rpm_q        <= rpm_d;
      kp_q         <= kp_d;
      ki_q         <= ki_d;
      kd_q         <= kd_d;
      en_q         <= en_d;
      cfg_q        <= cfg_d;
      err_q        <= err_d;
      code_q       <= code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_d        = cmd_q;
    dh_d         = dh_q;
    dl_d         = dl_q;
    pend_frame_d = 1'b0;
    pend_ok_d    = 1'b0;
    pend_to_d    = 1'b0;

    // A byte arriving on the expiry cycle takes priority over the timeout.
    if (bus.rx_data_valid) begin
      cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (bus.rx_data == HDR) begin
            state_d = S_CMD;
          end
        end
        S_CMD: begin
          cmd_d   = bus.rx_data;
          state_d = S_DH;
        end
        S_DH: begin
          dh_d    = bus.rx_data;
          state_d = S_DL;
        end
        S_DL: begin
          dl_d    = bus.rx_data;
          state_d = S_CHK;
        end
        S_CHK: begin
          pend_frame_d = 1'b1;
          pend_ok_d    = (bus.rx_data == (cmd_q ^ dh_q ^ dl_q));
          state_d      = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d     = '0;
      state_d   = S_IDLE;
      pend_to_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    rpm_d  = rpm_q;
    kp_d   = kp_q;
    ki_d   = ki_q;
    kd_d   = kd_q;
    en_d   = en_q;
    cfg_d  = 1'b0;
    err_d  = 1'b0;
    code_d = ERR_NONE;

    if (pend_to_q) begin
      err_d  = 1'b1;
      code_d = ERR_TO;
    end else if (pend_frame_q) begin
      if (!pend_ok_q) begin
        err_d  = 1'b1;
        code_d = ERR_CHK;
      end else begin
        case (cmd_q)
          CMD_SET_RPM: begin
            rpm_d = rpm_clamped;
            en_d  = 1'b1;
            cfg_d = 1'b1;
          end
          CMD_SET_KP: begin
            kp_d  = {dh_q, dl_q};
            cfg_d = 1'b1;
          end
          CMD_SET_KI: begin
            ki_d  = {dh_q, dl_q};
            cfg_d = 1'b1;
          end
          CMD_SET_KD: begin
            kd_d  = {dh_q, dl_q};
            cfg_d = 1'b1;
          end
          CMD_STOP: begin
            rpm_d = '0;
            en_d  = 1'b0;
            cfg_d = 1'b1;
          end
          default: begin
            err_d  = 1'b1;
            code_d = ERR_CMD;
          end
        endcase
      end
    end
  end

  assign bus.rpm_set_o    = rpm_q;
  assign bus.kp_o         = kp_q;
  assign bus.ki_o         = ki_q;
  assign bus.kd_o         = kd_q;
  assign bus.motor_en_o   = en_q;
  assign bus.cfg_update_o = cfg_q;
  assign bus.frame_err_o  = err_q;
  assign bus.err_code_o   = code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - directed frame sequence with a scoreboard of expected pulses
module tb_uart_cmd_parser;
  localparam int T = 40;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  uart_cmd_parser_if bus();

  uart_cmd_parser #(.TIMEOUT_CYC(T)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [15:0] rpm;
    logic [15:0] kp;
    logic [15:0] ki;
    logic [15:0] kd;
    logic        en;
    int          at;
  } exp_t;

  exp_t sbq[$];
  exp_t got_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 0;

  logic [15:0] m_rpm, m_kp, m_ki, m_kd;
  logic        m_en;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("pulse_exclusive", {31'd0, bus.cfg_update_o & bus.frame_err_o}, 32'd0);
      if (!bus.frame_err_o) check("err_code_idle", {30'd0, bus.err_code_o}, 32'd0);
      if (bus.cfg_update_o || bus.frame_err_o) begin
        checks++;
        assert (sbq.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_pulse: observed cfg=%0b err=%0b expected none", bus.cfg_update_o, bus.frame_err_o);
        end
        if (sbq.size() != 0) begin
          got_e = sbq.pop_front();
          check("pulse_cycle", cyc, got_e.at);
          check("pulse_is_err", {31'd0, bus.frame_err_o}, {31'd0, got_e.is_err});
          check("err_code", {30'd0, bus.err_code_o}, {30'd0, got_e.code});
          check("rpm", {16'd0, bus.rpm_set_o}, {16'd0, got_e.rpm});
          check("kp", {16'd0, bus.kp_o}, {16'd0, got_e.kp});
          check("ki", {16'd0, bus.ki_o}, {16'd0, got_e.ki});
          check("kd", {16'd0, bus.kd_o}, {16'd0, got_e.kd});
          check("motor_en", {31'd0, bus.motor_en_o}, {31'd0, got_e.en});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data_valid = 1'b1;
    bus.rx_data       = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_data_valid = 1'b0;
      bus.rx_data       = 8'h00;
    end
  endtask

  task automatic push_expect(input bit is_err, input logic [1:0] code, input int at);
    exp_t e;
    e.is_err = is_err;
    e.code   = code;
    e.rpm    = m_rpm;
    e.kp     = m_kp;
    e.ki     = m_ki;
    e.kd     = m_kd;
    e.en     = m_en;
    e.at     = at;
    sbq.push_back(e);
  endtask

  task automatic frame_body(input logic [7:0] cmd, input logic [7:0] dh, input logic [7:0] dl,
                            input logic [7:0] chk);
    int di;
    bit is_err;
    logic [1:0] code;
    send_byte(cmd);
    send_byte(dh);
    send_byte(dl);
    send_byte(chk);
    is_err = 0;
    code   = 2'b00;
    if (chk !== (cmd ^ dh ^ dl)) begin
      is_err = 1;
      code   = 2'b01;
    end else begin
      case (cmd)
        8'h01: begin
          di = $signed({dh, dl});
          if (di > 300) di = 300;
          if (di < -300) di = -300;
          m_rpm = di[15:0];
          m_en  = 1'b1;
        end
        8'h02: m_kp = {dh, dl};
        8'h03: m_ki = {dh, dl};
        8'h04: m_kd = {dh, dl};
        8'h05: begin
          m_rpm = 16'd0;
          m_en  = 1'b0;
        end
        default: begin
          is_err = 1;
          code   = 2'b10;
        end
      endcase
    end
    push_expect(is_err, code, cyc + 2);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] dh, input logic [7:0] dl,
                            input logic [7:0] chk);
    send_byte(8'hA5);
    frame_body(cmd, dh, dl, chk);
  endtask

  task automatic drain(input string tag);
    idle(4);
    check(tag, sbq.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rpm"}, {16'd0, bus.rpm_set_o}, 32'd0);
    check({tag, "_kp"}, {16'd0, bus.kp_o}, 32'd256);
    check({tag, "_ki"}, {16'd0, bus.ki_o}, 32'd16);
    check({tag, "_kd"}, {16'd0, bus.kd_o}, 32'd0);
    check({tag, "_en"}, {31'd0, bus.motor_en_o}, 32'd0);
    check({tag, "_cfg"}, {31'd0, bus.cfg_update_o}, 32'd0);
    check({tag, "_err"}, {31'd0, bus.frame_err_o}, 32'd0);
    check({tag, "_code"}, {30'd0, bus.err_code_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    m_rpm = 16'd0;
    m_kp  = 16'd256;
    m_ki  = 16'd16;
    m_kd  = 16'd0;
    m_en  = 1'b0;
    rstn  = 1'b0;
    bus.rx_data_valid = 1'b0;
    bus.rx_data       = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rstn   = 1'b1;
    mon_en = 1;
    idle(3);

    send_frame(8'h01, 8'h00, 8'hC8, 8'hC9);
    drain("rpm200_done");
    send_frame(8'h01, 8'h03, 8'hE8, 8'hEA);
    send_frame(8'h01, 8'hFC, 8'h18, 8'hE5);
    drain("clamp_done");

    send_frame(8'h02, 8'h01, 8'h00, 8'h00);
    send_frame(8'h07, 8'h00, 8'h00, 8'h07);
    drain("errors_done");

    send_frame(8'h02, 8'h01, 8'h80, 8'h83);
    send_frame(8'h03, 8'h00, 8'h20, 8'h23);
    send_frame(8'h04, 8'h00, 8'h05, 8'h01);
    send_frame(8'h01, 8'hFF, 8'h38, 8'hC6);
    send_frame(8'h01, 8'h80, 8'h00, 8'h81);
    drain("b2b_done");

    send_byte(8'hA5);
    send_byte(8'h01);
    m_rpm = m_rpm;
    push_expect(1, 2'b11, cyc + T + 2);
    idle(T + 6);
    check("timeout_done", sbq.size(), 0);
    send_frame(8'h05, 8'h00, 8'h00, 8'h05);
    drain("stop_done");
    check("stop_rpm", {16'd0, bus.rpm_set_o}, 32'd0);
    check("stop_en", {31'd0, bus.motor_en_o}, 32'd0);

    send_byte(8'h12);
    send_byte(8'hA5);
    frame_body(8'hA5, 8'h03, 8'h00, 8'h10);
    send_byte(8'h13);
    drain("junk_done");

    send_frame(8'h01, 8'h00, 8'h64, 8'h65);
    drain("rpm100_done");
    check("pre_reset_kp", {16'd0, bus.kp_o}, 32'h180);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h12);
    @(negedge clk);
    bus.rx_data_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check_reset_vals("midframe_reset");
    m_rpm = 16'd0;
    m_kp  = 16'd256;
    m_ki  = 16'd16;
    m_kd  = 16'd0;
    m_en  = 1'b0;
    send_byte(8'h34);
    send_byte(8'h24);
    drain("post_reset_done");
    check("post_reset_kp", {16'd0, bus.kp_o}, 32'd256);

    send_frame(8'h03, 8'h00, 8'h40, 8'h43);
    drain("resync_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
